// File: rtl/bsg_link_sdr_credit_upstream.sv
// bsg_link_sdr_credit_upstream
//
// Credit-flow-controlled upstream link transmitter. Each accepted core word
// is split into two beats (low half, then high half of every lane slice) and
// driven on CHANNELS registered output lanes. The number of words that may
// be outstanding is bounded by a credit counter. Token pulses from the
// downstream side replenish that counter.
//
// Optional feature macro: BSG_LINK_UPSTREAM_SKID_EN
//   When defined, a one-entry skid buffer is added. It lets a word be
//   accepted while BEAT0 is on the wire, and that word is issued directly
//   after BEAT1.
//
// Ports
//   clk           sole clock
//   rst           synchronous, active-high reset
//   core_valid_i  core word valid
//   core_data_i   core word, 2*CHANNELS*CH_WIDTH bits; lane k owns
//                 bits [k*2*CH_WIDTH +: 2*CH_WIDTH] (low beat first)
//   core_ready_o  word accepted when core_valid_i & core_ready_o
//   io_token_i    single-cycle credit-return pulse (already in clk domain)
//   io_valid_r_o  registered per-lane valid
//   io_data_r_o   registered lane data, lane k = [k*CH_WIDTH +: CH_WIDTH]
//   io_phase_r_o  registered beat phase, 0 = low beat, 1 = high beat
//   sent_cnt_o    words transmitted, mod 256
//   finish_cnt_o  credits returned, mod 256
//   credit_o      available credits
//   err_o         sticky token-overflow error
module bsg_link_sdr_credit_upstream #(
  parameter int CHANNELS         = 2,
  parameter int CH_WIDTH         = 8,
  parameter int CREDITS          = 8,
  parameter int TOKEN_DECIMATION = 2,
  localparam int CW              = $clog2(CREDITS + 1),
  localparam int WW              = 2 * CHANNELS * CH_WIDTH,
  localparam int LW              = CHANNELS * CH_WIDTH
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                core_valid_i,
  input  logic [WW-1:0]       core_data_i,
  output logic                core_ready_o,
  input  logic                io_token_i,
  output logic [CHANNELS-1:0] io_valid_r_o,
  output logic [LW-1:0]       io_data_r_o,
  output logic                io_phase_r_o,
  output logic [7:0]          sent_cnt_o,
  output logic [7:0]          finish_cnt_o,
  output logic [CW-1:0]       credit_o,
  output logic                err_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BEAT0 = 2'd1,
    BEAT1 = 2'd2
  } state_e;

  // Gather one beat out of a core word: for every lane pick the low or the
  // high CH_WIDTH slice of that lane's 2*CH_WIDTH field.
  function automatic logic [LW-1:0] beatHalf(input logic [WW-1:0] w, input logic hi);
    logic [LW-1:0] r;
    int            off;
    r   = '0;
    off = hi ? CH_WIDTH : 0;
    for (int k = 0; k < CHANNELS; k++) begin
      r[k*CH_WIDTH +: CH_WIDTH] = w[k*2*CH_WIDTH + off +: CH_WIDTH];
    end
    return r;
  endfunction

  state_e              state_q, state_d;
  logic [WW-1:0]       word_q, word_d;
  logic [LW-1:0]       ioData_q, ioData_d;
  logic [CHANNELS-1:0] ioValid_q, ioValid_d;
  logic                phase_q, phase_d;
  logic [7:0]          sentCnt_q, sentCnt_d;
  logic [7:0]          finishCnt_q, finishCnt_d;
  logic [CW-1:0]       credit_q, credit_d;
  logic                err_q, err_d;
  logic                accept;
  logic [31:0]         creditSum;

`ifdef BSG_LINK_UPSTREAM_SKID_EN
  logic [WW-1:0]       skid_q, skid_d;
  logic                skidFull_q, skidFull_d;

  // With the skid entry the only thing that blocks acceptance (besides
  // credit) is an occupied skid slot.
  assign core_ready_o = (credit_q != '0) & ~skidFull_q;
`else
  // Without skid a new word can only be taken when the wire is idle or is
  // carrying the last beat of the current word.
  assign core_ready_o = (credit_q != '0) & ((state_q == IDLE) | (state_q == BEAT1));
`endif

  assign accept = core_valid_i & core_ready_o;

  // Credit bookkeeping. An accept never underflows because ready requires a
  // nonzero credit; a token that would push the count past CREDITS saturates
  // it and raises the sticky error.
  always_comb begin
    finishCnt_d = finishCnt_q;
    err_d       = err_q;
    creditSum   = 32'(credit_q) - (accept ? 32'd1 : 32'd0);
    if (io_token_i) begin
      creditSum   = creditSum + 32'(TOKEN_DECIMATION);
      finishCnt_d = finishCnt_q + 8'(TOKEN_DECIMATION);
    end
    if (creditSum > 32'(CREDITS)) begin
      credit_d = CW'(CREDITS);
      err_d    = 1'b1;
    end else begin
      credit_d = creditSum[CW-1:0];
    end
  end

  // Beat sequencer. Output registers are loaded with the beat that becomes
  // visible after the edge, so a word accepted in cycle t shows its low beat
  // in t+1 and its high beat in t+2. The data lanes keep their last value
  // while idle; only valid drops.
  always_comb begin
    state_d   = state_q;
    word_d    = word_q;
    ioData_d  = ioData_q;
    ioValid_d = ioValid_q;
    phase_d   = phase_q;
    sentCnt_d = sentCnt_q;
`ifdef BSG_LINK_UPSTREAM_SKID_EN
    skid_d     = skid_q;
    skidFull_d = skidFull_q;
`endif
    case (state_q)
      IDLE: begin
        ioValid_d = '0;
        if (accept) begin
          state_d   = BEAT0;
          word_d    = core_data_i;
          ioData_d  = beatHalf(core_data_i, 1'b0);
          ioValid_d = '1;
          phase_d   = 1'b0;
        end
      end
      BEAT0: begin
        state_d   = BEAT1;
        ioData_d  = beatHalf(word_q, 1'b1);
        ioValid_d = '1;
        phase_d   = 1'b1;
        sentCnt_d = sentCnt_q + 8'd1;
`ifdef BSG_LINK_UPSTREAM_SKID_EN
        if (accept) begin
          skid_d     = core_data_i;
          skidFull_d = 1'b1;
        end
`endif
      end
      BEAT1: begin
`ifdef BSG_LINK_UPSTREAM_SKID_EN
        // A buffered word always goes first; ready is low while it waits,
        // so no direct accept can compete with it here.
        if (skidFull_q) begin
          state_d    = BEAT0;
          word_d     = skid_q;
          ioData_d   = beatHalf(skid_q, 1'b0);
          ioValid_d  = '1;
          phase_d    = 1'b0;
          skidFull_d = 1'b0;
        end else
`endif
        if (accept) begin
          state_d   = BEAT0;
          word_d    = core_data_i;
          ioData_d  = beatHalf(core_data_i, 1'b0);
          ioValid_d = '1;
          phase_d   = 1'b0;
        end else begin
          state_d   = IDLE;
          ioValid_d = '0;
        end
      end
      default: begin
        state_d   = IDLE;
        ioValid_d = '0;
      end
    endcase
  end

  // State and output registers; reset drops any word in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      word_q      <= '0;
      ioData_q    <= '0;
      ioValid_q   <= '0;
      phase_q     <= 1'b0;
      sentCnt_q   <= 8'd0;
      finishCnt_q <= 8'd0;
      credit_q    <= CW'(CREDITS);
      err_q       <= 1'b0;
`ifdef BSG_LINK_UPSTREAM_SKID_EN
      skid_q      <= '0;
      skidFull_q  <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      word_q      <= word_d;
      ioData_q    <= ioData_d;
      ioValid_q   <= ioValid_d;
      phase_q     <= phase_d;
      sentCnt_q   <= sentCnt_d;
      finishCnt_q <= finishCnt_d;
      credit_q    <= credit_d;
      err_q       <= err_d;
`ifdef BSG_LINK_UPSTREAM_SKID_EN
      skid_q      <= skid_d;
      skidFull_q  <= skidFull_d;
`endif
    end
  end

  assign io_valid_r_o = ioValid_q;
  assign io_data_r_o  = ioData_q;
  assign io_phase_r_o = phase_q;
  assign sent_cnt_o   = sentCnt_q;
  assign finish_cnt_o = finishCnt_q;
  assign credit_o     = credit_q;
  assign err_o        = err_q;

endmodule

// File: tb/tb_bsg_link_sdr_credit_upstream.sv
// Testbench for bsg_link_sdr_credit_upstream.
//
// A reference model keeps a queue of beats still to be put on the wire, a
// credit count and the two traffic counters. Every cycle the DUT outputs
// are compared against it, after a directed walk through the interesting
// credit situations and then a long randomized run.
module tb_bsg_link_sdr_credit_upstream;

   localparam int CHANNELS = 2;
   localparam int CH_WIDTH = 8;
   localparam int CREDITS  = 8;
   localparam int TD       = 2;
   localparam int CW       = $clog2(CREDITS + 1);
   localparam int WW       = 2 * CHANNELS * CH_WIDTH;
   localparam int LW       = CHANNELS * CH_WIDTH;

   typedef struct packed {
      logic [LW-1:0] data;
      logic          phase;
   } beat_t;

   logic                clk;
   logic                rst;
   logic                coreValid;
   logic [WW-1:0]       coreData;
   logic                coreReady;
   logic                ioToken;
   logic [CHANNELS-1:0] ioValid;
   logic [LW-1:0]       ioData;
   logic                ioPhase;
   logic [7:0]          sentCnt;
   logic [7:0]          finishCnt;
   logic [CW-1:0]       credit;
   logic                err;

   int nChecks;
   int nFails;

   // Reference model state
   beat_t      beatQ[$];
   int         mCredit;
   logic [7:0] mSent;
   logic [7:0] mFinish;
   logic       mErr;
   logic       mValid;
   logic [LW-1:0] mData;
   logic       mPhase;

   bsg_link_sdr_credit_upstream #(
      .CHANNELS(CHANNELS),
      .CH_WIDTH(CH_WIDTH),
      .CREDITS(CREDITS),
      .TOKEN_DECIMATION(TD)
   ) dut (
      .clk(clk),
      .rst(rst),
      .core_valid_i(coreValid),
      .core_data_i(coreData),
      .core_ready_o(coreReady),
      .io_token_i(ioToken),
      .io_valid_r_o(ioValid),
      .io_data_r_o(ioData),
      .io_phase_r_o(ioPhase),
      .sent_cnt_o(sentCnt),
      .finish_cnt_o(finishCnt),
      .credit_o(credit),
      .err_o(err)
   );

   // Free-running clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Single comparison point: counts every check and reports mismatches
   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      nChecks++;
      if (obs !== exp) begin
         nFails++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Lane k of a word holds its low beat then its high beat in a 2*CH_WIDTH field
   function automatic logic [LW-1:0] laneBeat(input logic [WW-1:0] w, input bit hi);
      logic [LW-1:0] r;
      r = '0;
      for (int k = 0; k < CHANNELS; k++)
         r[k*CH_WIDTH +: CH_WIDTH] = w[k*2*CH_WIDTH + (hi ? CH_WIDTH : 0) +: CH_WIDTH];
      return r;
   endfunction

   // Ready rule in terms of beats still waiting to go out: without skid a new
   // word fits only when nothing remains after the beat on the wire; the skid
   // entry allows one extra word's worth of pending beats.
   function automatic bit modelReady();
`ifdef BSG_LINK_UPSTREAM_SKID_EN
      return (mCredit != 0) && (beatQ.size() <= 1);
`else
      return (mCredit != 0) && (beatQ.size() == 0);
`endif
   endfunction

   task automatic resetModel();
      beatQ.delete();
      mCredit = CREDITS;
      mSent   = 8'd0;
      mFinish = 8'd0;
      mErr    = 1'b0;
      mValid  = 1'b0;
      mData   = '0;
      mPhase  = 1'b0;
   endtask

   task automatic checkAll();
      checkOutput("valid",  64'(ioValid),   mValid ? 64'((1 << CHANNELS) - 1) : 64'd0);
      checkOutput("data",   64'(ioData),    64'(mData));
      checkOutput("phase",  64'(ioPhase),   64'(mPhase));
      checkOutput("sent",   64'(sentCnt),   64'(mSent));
      checkOutput("finish", 64'(finishCnt), 64'(mFinish));
      checkOutput("credit", 64'(credit),    64'(mCredit));
      checkOutput("err",    64'(err),       64'(mErr));
   endtask

   // Drive one cycle of inputs (called at a falling edge), advance the model
   // by that cycle, then compare all outputs at the next falling edge.
   task automatic applyStimulus(input bit v, input logic [WW-1:0] d, input bit tok, input bit r);
      bit    acc;
      int    tmp;
      beat_t b;
      coreValid = v;
      coreData  = d;
      ioToken   = tok;
      rst       = r;
      #1;
      checkOutput("ready", 64'(coreReady), 64'(modelReady()));
      if (r) begin
         resetModel();
      end else begin
         acc = v && modelReady();
         if (acc) begin
            beatQ.push_back('{data: laneBeat(d, 1'b0), phase: 1'b0});
            beatQ.push_back('{data: laneBeat(d, 1'b1), phase: 1'b1});
         end
         tmp = mCredit - (acc ? 1 : 0) + (tok ? TD : 0);
         if (tok) mFinish = mFinish + 8'(TD);
         if (tmp > CREDITS) begin
            mCredit = CREDITS;
            mErr    = 1'b1;
         end else begin
            mCredit = tmp;
         end
         if (beatQ.size() > 0) begin
            b      = beatQ.pop_front();
            mValid = 1'b1;
            mData  = b.data;
            mPhase = b.phase;
            if (b.phase) mSent = mSent + 8'd1;
         end else begin
            mValid = 1'b0;
         end
      end
      @(posedge clk);
      @(negedge clk);
      checkAll();
   endtask

   initial begin
      nChecks   = 0;
      nFails    = 0;
      rst       = 1'b1;
      coreValid = 1'b0;
      coreData  = '0;
      ioToken   = 1'b0;
      resetModel();
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      checkAll();
      checkOutput("reset_credit", 64'(credit), 64'(CREDITS));

      // Single word: lanes {AA,CC} then {BB,DD}
      applyStimulus(1'b1, 32'hDDCCBBAA, 1'b0, 1'b0);
      checkOutput("w0_beat0", 64'(ioData), 64'h0000_CCAA);
      checkOutput("w0_valid0", 64'(ioValid), 64'd3);
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
      checkOutput("w0_beat1", 64'(ioData), 64'h0000_DDBB);
      checkOutput("w0_sent", 64'(sentCnt), 64'd1);
      checkOutput("w0_credit", 64'(credit), 64'd7);
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);

      // Hold valid with no tokens until the credits run dry
      for (int i = 0; i < 30; i++) applyStimulus(1'b1, 32'($urandom), 1'b0, 1'b0);
      checkOutput("dry_sent", 64'(sentCnt), 64'd8);
      checkOutput("dry_credit", 64'(credit), 64'd0);
      checkOutput("dry_ready", 64'(coreReady), 64'd0);
      checkOutput("dry_valid", 64'(ioValid), 64'd0);

      // One token returns two credits and lets two more words through
      applyStimulus(1'b1, 32'($urandom), 1'b1, 1'b0);
      checkOutput("tok_credit", 64'(credit), 64'd2);
      for (int i = 0; i < 10; i++) applyStimulus(1'b1, 32'($urandom), 1'b0, 1'b0);
      checkOutput("tok_sent", 64'(sentCnt), 64'd10);
      checkOutput("tok_finish", 64'(finishCnt), 64'd2);

      // Reach credit 3, then accept and token together
      applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
      applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
      applyStimulus(1'b1, 32'($urandom), 1'b0, 1'b0);
      checkOutput("pre_credit", 64'(credit), 64'd3);
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
      applyStimulus(1'b1, 32'($urandom), 1'b1, 1'b0);
      checkOutput("both_credit", 64'(credit), 64'd4);
      for (int i = 0; i < 3; i++) applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);

      // Overflow: 4 -> 6 -> 8 -> saturate with error
      applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
      applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
      applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
      checkOutput("ovf_credit", 64'(credit), 64'd8);
      checkOutput("ovf_err", 64'(err), 64'd1);
      for (int i = 0; i < 3; i++) applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
      checkOutput("ovf_sticky", 64'(err), 64'd1);

      // Reset while BEAT0 is on the wire
      applyStimulus(1'b1, 32'($urandom), 1'b0, 1'b0);
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
      checkOutput("rst_valid", 64'(ioValid), 64'd0);
      checkOutput("rst_credit", 64'(credit), 64'd8);
      checkOutput("rst_sent", 64'(sentCnt), 64'd0);
      checkOutput("rst_err", 64'(err), 64'd0);
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
      checkOutput("rst_nobeat", 64'(ioValid), 64'd0);

      // Randomized traffic with varying token density and rare resets
      for (int i = 0; i < 1500; i++) begin
         int tokPct;
         tokPct = (i < 750) ? 12 : 35;
         applyStimulus($urandom_range(99) < 70, 32'($urandom),
                       $urandom_range(99) < tokPct, $urandom_range(199) == 0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end

endmodule

// File: doc/bsg_link_sdr_credit_upstream.md
# bsg_link_sdr_credit_upstream

Parametrised, credit-flow-controlled upstream link transmitter. It accepts wide core words on a valid/ready handshake and serialises each word as two beats across CHANNELS output lanes. Outstanding words are bounded by a credit counter that is replenished by token pulses from the downstream side. It replaces the fixed two-channel, 8-bit-per-phase upstream path with a single-clock, width-, lane- and credit-generic block. It exports sent/finished counters directly, so refinement checks need no hierarchy probing.

## Interface
- CHANNELS, 2, number of output lanes
- CH_WIDTH, 8, data bits per lane per beat
- CREDITS, 8, maximum outstanding words; must be a multiple of TOKEN_DECIMATION
- TOKEN_DECIMATION, 2, credits returned per token pulse
- clk  in  1  sole clock
- rst  in  1  synchronous, active-high reset
- core_valid_i  in  1  core word valid
- core_data_i  in  2*CHANNELS*CH_WIDTH  core word
- core_ready_o  out  1  word accepted on valid&ready
- io_token_i  in  1  single-cycle credit-return pulse, already synchronised to clk
- io_valid_r_o  out  CHANNELS  registered per-lane valid
- io_data_r_o  out  CHANNELS*CH_WIDTH  registered lane data; lane k = bits [k*CH_WIDTH +: CH_WIDTH]
- io_phase_r_o  out  1  0 = low beat, 1 = high beat
- sent_cnt_o  out  8  words transmitted, mod 256
- finish_cnt_o  out  8  credits returned, mod 256
- credit_o  out  CW = $clog2(CREDITS+1)  available credits
- err_o  out  1  sticky token-overflow error

## Operation
- FSM states: IDLE, BEAT0, BEAT1.
- A word is accepted when core_valid_i & core_ready_o. Acceptance latches the word and decrements credit.
- Beat order:
  - BEAT0 drives the low half per lane. Lane k = core_data_i[k*2*CH_WIDTH +: CH_WIDTH].
  - BEAT1 drives the high half per lane. Lane k = core_data_i[k*2*CH_WIDTH+CH_WIDTH +: CH_WIDTH].
- In BEAT0 and BEAT1, io_valid_r_o is all ones. In IDLE, io_valid_r_o is 0 and io_data_r_o holds its last value.
- Without skid, core_ready_o = (credit_o != 0) & (state is IDLE or BEAT1). This is purely combinational from registered state.
- Transitions:
  - IDLE→BEAT0 on accept.
  - BEAT0→BEAT1 unconditionally.
  - BEAT1→BEAT0 if a word was accepted in BEAT1 or is buffered; otherwise BEAT1→IDLE.
- sent_cnt_o increments when BEAT1 is entered.
- Token handling:
  - Each io_token_i pulse adds TOKEN_DECIMATION to the credit and adds TOKEN_DECIMATION to finish_cnt_o.
  - An accept and a token in the same cycle apply both: net credit change = +TOKEN_DECIMATION−1.
  - If the sum exceeds CREDITS, credit saturates at CREDITS and err_o sets. err_o clears only on rst.
- credit_o = 0 forces core_ready_o low. A word already accepted still completes both beats.
- Counters wrap mod 256 silently.
- Reset values:
  - state IDLE, credit_o = CREDITS, sent_cnt_o = 0, finish_cnt_o = 0, err_o = 0.
  - io_valid_r_o = 0, io_data_r_o = 0, io_phase_r_o = 0, skid empty.
- Reset mid-word aborts the word; no further beat is emitted.

## Timing
- Accept in cycle t → BEAT0 on outputs in cycle t+1 → BEAT1 in cycle t+2.
- Peak throughput is one word per 2 cycles with no idle beat between back-to-back words.
- A token in cycle t is visible on credit_o in cycle t+1. It can enable core_ready_o in cycle t+1.
- io_phase_r_o is registered alongside the data and toggles every active beat.

## Configuration
- Macro: BSG_LINK_UPSTREAM_SKID_EN.
- Defined:
  - A one-entry skid buffer is added, and core_ready_o = (credit_o != 0) & ~skid_full.
  - A word accepted in BEAT0 is held and issued immediately after BEAT1; it consumes its credit at acceptance.
  - The skid buffer empties on rst.
- Undefined: no skid buffer; ready follows the rule in Operation. Behaviour otherwise identical.

## Test plan
- Reset, CHANNELS=2, CH_WIDTH=8: accept 0xDDCCBBAA → BEAT0 lanes {0xAA,0xCC}, BEAT1 lanes {0xBB,0xDD}, io_valid_r_o=2'b11 both beats, then sent_cnt_o=1, credit_o=7.
- Hold valid with no tokens, CREDITS=8 → exactly 8 words sent, core_ready_o=0 afterwards, credit_o=0, outputs return to IDLE.
- At credit_o=0, pulse io_token_i once → next cycle credit_o=2, two more words sent, finish_cnt_o=2.
- Accept and token in the same cycle at credit_o=3 → credit_o=4.
- With credit_o=8, pulse a token → credit_o stays 8, err_o=1 and stays 1 until rst.
- Assert rst during BEAT0 of a word → next cycle io_valid_r_o=0, credit_o=8, sent_cnt_o=0. With skid enabled, buffered words are dropped and the two-word issue gap becomes 0 idle cycles.
